// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the registered ROM address and assembles
// 1- or 2-word instructions for decode over a valid/ready handshake.
module ins_fetch_ctrl #(
  parameter int unsigned      AddrW    = 16,
  parameter int unsigned      DataW    = 16,
  parameter logic [AddrW-1:0] ResetPc  = '0,
  parameter logic [AddrW-1:0] LastAddr = 16'h0008
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic [AddrW-1:0] rom_addr_o,
  input  logic [AddrW-1:0] rom_addr_in_i,
  input  logic [DataW-1:0] rom_data_i,
  input  logic             redir_valid_i,
  input  logic [AddrW-1:0] redir_pc_i,
  output logic             instr_valid_o,
  input  logic             dec_ready_i,
  output logic [DataW-1:0] instr_w0_o,
  output logic [DataW-1:0] instr_w1_o,
  output logic [1:0]       instr_len_o,
  output logic [AddrW-1:0] instr_pc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {StIdle, StA1, StD1, StA2, StD2, StIssue, StDone} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] rom_addr_q, rom_addr_d;
  logic [AddrW-1:0] instr_pc_q, instr_pc_d;
  logic [DataW-1:0] w0_q, w0_d;
  logic [DataW-1:0] w1_q, w1_d;
  logic [1:0]       len_q, len_d;
  logic             err_q, err_d;

  logic             is_two;
  logic             echo_bad;
  logic             redir_take;
  logic [AddrW:0]   npc_ext;

  assign is_two     = (rom_data_i[13:12] == 2'b10);
  assign echo_bad   = (rom_addr_in_i != rom_addr_q);
  assign redir_take = redir_valid_i && (state_q != StIdle);
  // One extra bit so a wrap past the top of the address space reads as "beyond LastAddr".
  assign npc_ext    = {1'b0, pc_q} + {{(AddrW-1){1'b0}}, len_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rom_addr_d = rom_addr_q;
    instr_pc_d = instr_pc_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    len_d      = len_q;
    err_d      = err_q;

    if (redir_take) begin
      pc_d       = redir_pc_i;
      rom_addr_d = redir_pc_i;
      state_d    = (redir_pc_i > LastAddr) ? StDone : StA1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            rom_addr_d = pc_q;
            state_d    = StA1;
          end
        end
        StA1: state_d = StD1;
        StD1: begin
          w0_d       = rom_data_i;
          instr_pc_d = pc_q;
          if (echo_bad) err_d = 1'b1;
          if (is_two) begin
            if (pc_q < LastAddr) begin
              rom_addr_d = pc_q + AddrW'(1);
              state_d    = StA2;
            end else begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          end else begin
            w1_d    = '0;
            len_d   = 2'd1;
            state_d = StIssue;
          end
        end
        StA2: state_d = StD2;
        StD2: begin
          w1_d    = rom_data_i;
          len_d   = 2'd2;
          if (echo_bad) err_d = 1'b1;
          state_d = StIssue;
        end
        StIssue: begin
          if (dec_ready_i) begin
            if (npc_ext > {1'b0, LastAddr}) begin
              state_d = StDone;
            end else begin
              pc_d       = npc_ext[AddrW-1:0];
              rom_addr_d = npc_ext[AddrW-1:0];
              state_d    = StA1;
            end
          end
        end
        StDone: begin
          if (start_i) begin
            pc_d       = ResetPc;
            rom_addr_d = ResetPc;
            err_d      = 1'b0;
            state_d    = StA1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      rom_addr_q <= ResetPc;
      instr_pc_q <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      instr_pc_q <= instr_pc_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign instr_valid_o = (state_q == StIssue);
  assign instr_w0_o    = w0_q;
  assign instr_w1_o    = w1_q;
  assign instr_len_o   = len_q;
  assign instr_pc_o    = instr_pc_q;
  assign busy_o        = (state_q == StA1) || (state_q == StD1) || (state_q == StA2) ||
                         (state_q == StD2) || (state_q == StIssue);
  assign done_o        = (state_q == StDone);
  assign err_o         = err_q;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed bench for ins_fetch_ctrl: a registered ROM model plus a vector table of redirect
// targets, and hand-written sequences for reset, stall, end-of-program and error cases.
module tb_ins_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] rom_addr_o;
  logic [15:0] rom_addr_in_i;
  logic [15:0] rom_data_i;
  logic        redir_valid_i;
  logic [15:0] redir_pc_i;
  logic        instr_valid_o;
  logic        dec_ready_i;
  logic [15:0] instr_w0_o;
  logic [15:0] instr_w1_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  logic [15:0] mem [16];
  logic        corrupt;
  int          n_vec = 0;
  int          n_err = 0;

  ins_fetch_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .rom_addr_o    (rom_addr_o),
    .rom_addr_in_i (rom_addr_in_i),
    .rom_data_i    (rom_data_i),
    .redir_valid_i (redir_valid_i),
    .redir_pc_i    (redir_pc_i),
    .instr_valid_o (instr_valid_o),
    .dec_ready_i   (dec_ready_i),
    .instr_w0_o    (instr_w0_o),
    .instr_w1_o    (instr_w1_o),
    .instr_len_o   (instr_len_o),
    .instr_pc_o    (instr_pc_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Registered ROM: address seen in cycle t, data and echo visible in cycle t+1.
  always @(posedge clk_i) begin
    rom_data_i    <= mem[rom_addr_o[3:0]];
    rom_addr_in_i <= rom_addr_o ^ {15'b0, corrupt};
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [1:0]  len;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Caller sets the pulse inputs; they are cleared after the first edge.
  task automatic run_to_valid(output int lat);
    step();
    start_i       = 1'b0;
    redir_valid_i = 1'b0;
    dec_ready_i   = 1'b0;
    lat = 1;
    while (!instr_valid_o && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic accept();
    dec_ready_i = 1'b1;
    step();
    dec_ready_i = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [15:0] exp_ra;
    logic        seen;

    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1B5C; mem[3] = 16'hADCC; mem[4] = 16'h8449;
    mem[5] = 16'h1015; mem[6] = 16'h121D; mem[8] = 16'h1486;

    vecs[0] = '{16'd3, 16'hADCC, 16'h8449, 2'd2, 5, 0};
    vecs[1] = '{16'd5, 16'h1015, 16'h0000, 2'd1, 3, 4};
    vecs[2] = '{16'd6, 16'h121D, 16'h0000, 2'd1, 3, 0};
    vecs[3] = '{16'd4, 16'h8449, 16'h0000, 2'd1, 3, 2};
    vecs[4] = '{16'd0, 16'h1B5C, 16'h0000, 2'd1, 3, 0};
    vecs[5] = '{16'd7, 16'h0000, 16'h0000, 2'd1, 3, 0};

    rst_ni = 1'b0; start_i = 1'b0; redir_valid_i = 1'b0; redir_pc_i = '0;
    dec_ready_i = 1'b0; corrupt = 1'b0;
    step(); step();
    chk("rst rom_addr", rom_addr_o, 0);
    chk("rst valid", instr_valid_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst err", err_o, 0);
    chk("rst len", instr_len_o, 0);
    rst_ni = 1'b1;
    step();

    // Redirect in IDLE is ignored
    redir_valid_i = 1'b1; redir_pc_i = 16'd3;
    step();
    redir_valid_i = 1'b0;
    chk("idle redir busy", busy_o, 0);
    chk("idle redir addr", rom_addr_o, 0);

    // T1
    start_i = 1'b1;
    run_to_valid(lat);
    chk("t1 latency", lat, 3);
    chk("t1 w0", instr_w0_o, 16'h1B5C);
    chk("t1 len", instr_len_o, 1);
    chk("t1 pc", instr_pc_o, 0);
    accept();
    chk("t1 next addr", rom_addr_o, 1);
    chk("t1 busy", busy_o, 1);

    // T2: sequential follow-on after a 2-word instruction
    redir_valid_i = 1'b1; redir_pc_i = 16'd3;
    run_to_valid(lat);
    chk("t2 w0", instr_w0_o, 16'hADCC);
    chk("t2 w1", instr_w1_o, 16'h8449);
    dec_ready_i = 1'b1;
    run_to_valid(lat);
    chk("t2 next w0", instr_w0_o, 16'h1015);
    chk("t2 next pc", instr_pc_o, 5);
    accept();

    // Redirect table, with optional decode stall before accept
    for (int v = 0; v < 6; v++) begin
      redir_valid_i = 1'b1; redir_pc_i = vecs[v].addr;
      run_to_valid(lat);
      chk($sformatf("v%0d latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d w0", v), instr_w0_o, vecs[v].w0);
      chk($sformatf("v%0d w1", v), instr_w1_o, vecs[v].w1);
      chk($sformatf("v%0d len", v), instr_len_o, vecs[v].len);
      chk($sformatf("v%0d pc", v), instr_pc_o, vecs[v].addr);
      exp_ra = vecs[v].addr + 16'(vecs[v].len) - 16'd1;
      for (int h = 0; h < vecs[v].hold; h++) begin
        step();
        chk($sformatf("v%0d hold valid", v), instr_valid_o, 1);
        chk($sformatf("v%0d hold w0", v), instr_w0_o, vecs[v].w0);
        chk($sformatf("v%0d hold addr", v), rom_addr_o, exp_ra);
      end
      accept();
      chk($sformatf("v%0d valid drop", v), instr_valid_o, 0);
      chk($sformatf("v%0d next addr", v), rom_addr_o, vecs[v].addr + 16'(vecs[v].len));
    end

    // T4: end of program and restart
    redir_valid_i = 1'b1; redir_pc_i = 16'd8;
    run_to_valid(lat);
    chk("t4 w0", instr_w0_o, 16'h1486);
    accept();
    chk("t4 done", done_o, 1);
    chk("t4 busy", busy_o, 0);
    chk("t4 valid", instr_valid_o, 0);
    start_i = 1'b1;
    run_to_valid(lat);
    chk("t4 restart latency", lat, 3);
    chk("t4 restart w0", instr_w0_o, 16'h1B5C);
    chk("t4 restart pc", instr_pc_o, 0);

    // Same-cycle accept and redirect
    dec_ready_i = 1'b1; redir_valid_i = 1'b1; redir_pc_i = 16'd3;
    run_to_valid(lat);
    chk("acc+redir latency", lat, 5);
    chk("acc+redir w0", instr_w0_o, 16'hADCC);
    chk("acc+redir pc", instr_pc_o, 3);

    // Redirect past LastAddr
    redir_valid_i = 1'b1; redir_pc_i = 16'd9;
    step();
    redir_valid_i = 1'b0;
    chk("redir far done", done_o, 1);
    chk("redir far valid", instr_valid_o, 0);

    // T5: echo mismatch, sticky err, reset mid-D2
    corrupt = 1'b1; start_i = 1'b1;
    run_to_valid(lat);
    corrupt = 1'b0;
    chk("t5 err", err_o, 1);
    dec_ready_i = 1'b1;
    run_to_valid(lat);
    chk("t5 err sticky", err_o, 1);
    chk("t5 clean w0", instr_w0_o, 16'h0000);
    redir_valid_i = 1'b1; redir_pc_i = 16'd3;
    step();
    redir_valid_i = 1'b0;
    step(); step(); step();
    chk("t5 in D2 addr", rom_addr_o, 4);
    rst_ni = 1'b0;
    #1;
    chk("t5 async busy", busy_o, 0);
    chk("t5 async err", err_o, 0);
    chk("t5 async addr", rom_addr_o, 0);
    chk("t5 async w0", instr_w0_o, 0);
    chk("t5 async w1", instr_w1_o, 0);
    chk("t5 async pc", instr_pc_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // T6: 2-word opcode at LastAddr is truncated
    mem[8] = 16'h2000;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    redir_valid_i = 1'b1; redir_pc_i = 16'd8;
    step();
    redir_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (instr_valid_o) seen = 1'b1;
    end
    chk("t6 err", err_o, 1);
    chk("t6 done", done_o, 1);
    chk("t6 no valid", seen, 0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t6 start clears err", err_o, 0);
    chk("t6 start busy", busy_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
